mem_ctrl_ifetch: RTL and testbench

- Memory-side responder for the instruction-fetch request protocol.
- Accepts a one-cycle fetch request (need_fetch, fetch_pc) from the instruction fetcher.
- Reads four bytes from the byte-wide RAM port, assembles them little-endian, and returns one 32-bit instruction with a one-cycle valid pulse.
- Sits between the fetcher and the RAM arbiter; honours ROB roll-back by aborting any in-flight fetch.

---
 rtl/mem_ctrl_ifetch_pkg.sv | 21 ++
 rtl/mem_ctrl_ifetch_if.sv | 27 ++
 rtl/mem_ctrl_ifetch.sv | 105 ++++++++++
 tb/tb_mem_ctrl_ifetch.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_ifetch_pkg.sv
// Shared constants and state type for the instruction-fetch memory responder.
package mem_ctrl_ifetch_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam int ADDR_WIDTH   = 32;
    localparam int INST_WIDTH   = 32;
    localparam int IFETCH_BYTES = 4;

    // Last counter value that still drives an address, and the completion value
    // (the top byte arrives two edges after its address was presented).
    localparam logic [2:0] CNT_ADDR_LAST = 3'(IFETCH_BYTES - 1);
    localparam logic [2:0] CNT_LAST      = 3'(IFETCH_BYTES + 1);

    typedef enum logic {
        IFETCH_IDLE = 1'b0,
        IFETCH_BUSY = 1'b1
    } ifetch_state_e;

endpackage

// File: rtl/mem_ctrl_ifetch_if.sv
// Fetch-request handshake plus byte-wide RAM port; slave is the memory-side responder.
interface mem_ctrl_ifetch_if;
    import mem_ctrl_ifetch_pkg::*;

    logic                  IF_need_fetch;
    logic [ADDR_WIDTH-1:0] IF_fetch_pc;
    logic                  IF_output_valid;
    logic [INST_WIDTH-1:0] IF_inst;
    logic                  ext_port_busy;
    logic                  ifetch_busy;
    logic [7:0]            mem_din;
    logic [ADDR_WIDTH-1:0] mem_a;
    logic [7:0]            mem_dout;
    logic                  mem_wr;
    logic                  ROB_roll_back_flag;

    modport master (
        output IF_need_fetch, IF_fetch_pc, ext_port_busy, mem_din, ROB_roll_back_flag,
        input  IF_output_valid, IF_inst, ifetch_busy, mem_a, mem_dout, mem_wr
    );

    modport slave (
        input  IF_need_fetch, IF_fetch_pc, ext_port_busy, mem_din, ROB_roll_back_flag,
        output IF_output_valid, IF_inst, ifetch_busy, mem_a, mem_dout, mem_wr
    );

endinterface

// File: rtl/mem_ctrl_ifetch.sv
// Instruction-fetch responder: reads four RAM bytes and returns one little-endian word.
// Optional fetch/abort counters are enabled by defining MEM_CTRL_IFETCH_STATS_EN.
module mem_ctrl_ifetch
    import mem_ctrl_ifetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    mem_ctrl_ifetch_if.slave   bus
`ifdef MEM_CTRL_IFETCH_STATS_EN
    ,
    output logic [31:0]        stat_fetch_done,
    output logic [31:0]        stat_fetch_abort
`endif
);

    ifetch_state_e         state;
    logic [2:0]            cnt;
    logic [ADDR_WIDTH-1:0] base;
    logic [ADDR_WIDTH-1:0] pend_pc;
    logic                  pending;

    logic                  start;
    logic                  complete;
    logic [ADDR_WIDTH-1:0] start_pc;
    logic [1:0]            byte_idx;

    // A fresh request overrides one left pending while the port was taken.
    assign start    = (bus.IF_need_fetch || pending) && !bus.ext_port_busy;
    assign start_pc = bus.IF_need_fetch ? bus.IF_fetch_pc : pend_pc;
    assign complete = (state == IFETCH_BUSY) && (cnt == CNT_LAST);
    assign byte_idx = 2'(cnt - 3'd2);

    assign bus.mem_dout = 8'h00;
    assign bus.mem_wr   = FALSE;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state               <= IFETCH_IDLE;
            cnt                 <= 3'd0;
            base                <= '0;
            pend_pc             <= '0;
            pending             <= FALSE;
            bus.mem_a           <= '0;
            bus.IF_output_valid <= FALSE;
            bus.IF_inst         <= '0;
            bus.ifetch_busy     <= FALSE;
        end else if (rdy) begin
            bus.IF_output_valid <= FALSE;
            if (bus.ROB_roll_back_flag) begin
                state           <= IFETCH_IDLE;
                cnt             <= 3'd0;
                pending         <= FALSE;
                bus.ifetch_busy <= FALSE;
            end else begin
                case (state)
                    IFETCH_IDLE: begin
                        if (start) begin
                            state           <= IFETCH_BUSY;
                            base            <= start_pc;
                            bus.mem_a       <= start_pc;
                            cnt             <= 3'd1;
                            pending         <= FALSE;
                            bus.ifetch_busy <= TRUE;
                        end else if (bus.IF_need_fetch) begin
                            pending <= TRUE;
                            pend_pc <= bus.IF_fetch_pc;
                        end
                    end
                    IFETCH_BUSY: begin
                        if (cnt <= CNT_ADDR_LAST)
                            bus.mem_a <= base + ADDR_WIDTH'(cnt);
                        // RAM data trails the address by two edges, hence the cnt-2 lane.
                        if (cnt >= 3'd2)
                            bus.IF_inst[{byte_idx, 3'b000} +: 8] <= bus.mem_din;
                        if (complete) begin
                            state               <= IFETCH_IDLE;
                            cnt                 <= 3'd0;
                            bus.IF_output_valid <= TRUE;
                            bus.ifetch_busy     <= FALSE;
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                    default: state <= IFETCH_IDLE;
                endcase
            end
        end
    end

`ifdef MEM_CTRL_IFETCH_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_fetch_done  <= '0;
            stat_fetch_abort <= '0;
        end else if (rdy) begin
            if (complete && !bus.ROB_roll_back_flag)
                stat_fetch_done <= stat_fetch_done + 32'd1;
            if (bus.ROB_roll_back_flag && (state == IFETCH_BUSY || pending))
                stat_fetch_abort <= stat_fetch_abort + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_ctrl_ifetch.sv
// Scoreboard bench for mem_ctrl_ifetch: directed protocol cases plus randomized fetches.
module tb_mem_ctrl_ifetch;
    import mem_ctrl_ifetch_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rdy = 1'b1;

    always #5 clk = ~clk;

    mem_ctrl_ifetch_if bus ();

`ifdef MEM_CTRL_IFETCH_STATS_EN
    logic [31:0] stat_fetch_done;
    logic [31:0] stat_fetch_abort;
`endif

    mem_ctrl_ifetch dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
`ifdef MEM_CTRL_IFETCH_STATS_EN
        ,
        .stat_fetch_done  (stat_fetch_done),
        .stat_fetch_abort (stat_fetch_abort)
`endif
    );

    typedef struct {
        logic [31:0] inst;
        int unsigned due;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    int unsigned edge_cnt    = 0;
    int unsigned wall_cnt    = 0;
    logic        last_active = 1'b0;
    logic        mon_en      = 1'b0;
    int unsigned done_exp    = 0;
    int unsigned abort_exp   = 0;

    // Sparse RAM contents: a small program word at 0, a scrambled pattern elsewhere.
    function automatic logic [7:0] ram_byte(input logic [31:0] a);
        if (a < 32'd4)
            return (a == 32'd0) ? 8'h13 : 8'h00;
        return (a[7:0] * 8'd29) ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h6B;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] pc);
        logic [31:0] w;
        for (int k = 0; k < 4; k++)
            w[8*k +: 8] = ram_byte(pc + 32'(k));
        return w;
    endfunction

    // RAM answers one edge after sampling the address and pauses with rdy.
    always @(posedge clk) begin
        if (rdy)
            bus.mem_din <= ram_byte(bus.mem_a);
    end

    always @(posedge clk) begin
        wall_cnt    <= wall_cnt + 1;
        last_active <= rst && rdy;
        if (rst && rdy)
            edge_cnt <= edge_cnt + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic need, input logic [31:0] pc, input logic ext,
                                 input logic rb, input logic r);
        bus.IF_need_fetch      = need;
        bus.IF_fetch_pc        = pc;
        bus.ext_port_busy      = ext;
        bus.ROB_roll_back_flag = rb;
        rdy                    = r;
    endtask

    // Called at a negedge just before the accepting edge.
    task automatic pushExpect(input logic [31:0] pc);
        exp_t e;
        e.inst = ref_word(pc);
        e.due  = edge_cnt + 6;
        exp_q.push_back(e);
        done_exp++;
    endtask

    task automatic waitValid(input string name, input int budget);
        int n = 0;
        while (!(bus.IF_output_valid && last_active) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, 32'(bus.IF_output_valid), 32'd1);
    endtask

    // Monitor: pops the scoreboard on every fresh valid pulse.
    always @(negedge clk) begin
        if (mon_en) begin
            checkOutput("mem_wr", 32'(bus.mem_wr), 32'd0);
            checkOutput("mem_dout", 32'(bus.mem_dout), 32'd0);
            if (bus.IF_output_valid && last_active) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_valid", 32'(bus.IF_output_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checkOutput("inst", bus.IF_inst, e.inst);
                    checkOutput("valid_edge", edge_cnt, e.due);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int unsigned ws;
        bus.mem_din = 8'h00;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

        // Reset held for three cycles
        rst = 1'b0;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        checkOutput("rst_mem_a", bus.mem_a, 32'h0);
        checkOutput("rst_valid", 32'(bus.IF_output_valid), 32'd0);
        checkOutput("rst_inst", bus.IF_inst, 32'h0);
        checkOutput("rst_busy", 32'(bus.ifetch_busy), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_busy", 32'(bus.ifetch_busy), 32'd0);
        checkOutput("post_rst_valid", 32'(bus.IF_output_valid), 32'd0);

        // Plain fetch from address 0
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 1'b1);
        pushExpect(32'h0);
        @(negedge clk);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        checkOutput("f0_busy", 32'(bus.ifetch_busy), 32'd1);
        checkOutput("f0_mem_a0", bus.mem_a, 32'h0);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            checkOutput("f0_mem_a", bus.mem_a, 32'(i));
        end
        waitValid("f0_valid", 10);
        checkOutput("f0_busy_done", 32'(bus.ifetch_busy), 32'd0);
        @(negedge clk);
        checkOutput("f0_valid_clear", 32'(bus.IF_output_valid), 32'd0);

        // Request while another master owns the port
        applyStimulus(1'b1, 32'h104, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            applyStimulus(1'b0, 32'h0, (i < 2) ? 1'b1 : 1'b0, 1'b0, 1'b1);
            if (i < 3) begin
                checkOutput("ext_mem_a_hold", bus.mem_a, 32'h3);
                checkOutput("ext_no_busy", 32'(bus.ifetch_busy), 32'd0);
            end
            if (i == 2)
                pushExpect(32'h104);
        end
        checkOutput("ext_start_mem_a", bus.mem_a, 32'h104);
        checkOutput("ext_start_busy", 32'(bus.ifetch_busy), 32'd1);
        waitValid("ext_valid", 10);

        // Roll-back at edge N+3, new request accepted at N+4
        @(negedge clk);
        applyStimulus(1'b1, 32'h200, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        abort_exp++;
        @(negedge clk);
        checkOutput("rb_busy", 32'(bus.ifetch_busy), 32'd0);
        checkOutput("rb_mem_a_hold", bus.mem_a, 32'h202);
        applyStimulus(1'b1, 32'h300, 1'b0, 1'b0, 1'b1);
        pushExpect(32'h300);
        @(negedge clk);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        checkOutput("rb_restart_mem_a", bus.mem_a, 32'h300);
        waitValid("rb_restart_valid", 10);

        // Two-cycle rdy stall in the middle of a fetch
        @(negedge clk);
        ws = wall_cnt;
        applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 1'b1);
        pushExpect(32'h40);
        @(negedge clk);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("stall_mem_a", bus.mem_a, 32'h42);
        @(negedge clk);
        checkOutput("stall_busy", 32'(bus.ifetch_busy), 32'd1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        waitValid("stall_valid", 12);
        checkOutput("stall_latency", 32'(wall_cnt - ws), 32'd8);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("stall_valid_held", 32'(bus.IF_output_valid), 32'd1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("stall_valid_clear", 32'(bus.IF_output_valid), 32'd0);

        // Address wrap past the top of memory
        applyStimulus(1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1);
        pushExpect(32'hFFFF_FFFE);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
            checkOutput("wrap_mem_a", bus.mem_a, 32'hFFFF_FFFE + 32'(i));
        end
        waitValid("wrap_valid", 10);

        // Randomized fetches with port contention, stalls, stray requests and aborts
        for (int it = 0; it < 40; it++) begin
            logic [31:0] pc;
            int unsigned eb, r, e0, d, guard;
            logic        abort, done;
            pc    = $urandom;
            eb    = $urandom_range(0, 2);
            r     = $urandom_range(1, 5);
            abort = ($urandom_range(0, 3) == 0);
            repeat ($urandom_range(1, 3)) @(negedge clk);
            if (eb > 0) begin
                applyStimulus(1'b1, pc, 1'b1, 1'b0, 1'b1);
                for (int i = 1; i < int'(eb); i++) begin
                    @(negedge clk);
                    applyStimulus(1'b0, $urandom, 1'b1, 1'b0, 1'b1);
                end
                @(negedge clk);
                applyStimulus(1'b0, $urandom, 1'b0, 1'b0, 1'b1);
            end else begin
                applyStimulus(1'b1, pc, 1'b0, 1'b0, 1'b1);
            end
            e0 = edge_cnt;
            if (!abort)
                pushExpect(pc);
            done  = 1'b0;
            guard = 0;
            @(negedge clk);
            while (!done && guard < 200) begin
                guard++;
                d = edge_cnt - e0;
                if (abort && d == r) begin
                    applyStimulus(1'($urandom_range(0, 1)), $urandom, 1'b0, 1'b1, 1'b1);
                    abort_exp++;
                    @(negedge clk);
                    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
                    checkOutput("rand_rb_busy", 32'(bus.ifetch_busy), 32'd0);
                    done = 1'b1;
                end else if (!abort && d == 6) begin
                    done = 1'b1;
                end else begin
                    applyStimulus(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                                  1'b0, ($urandom_range(0, 3) != 0));
                    @(negedge clk);
                end
            end
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        end
        repeat (8) @(negedge clk);

`ifdef MEM_CTRL_IFETCH_STATS_EN
        checkOutput("stat_done", stat_fetch_done, 32'(done_exp));
        checkOutput("stat_abort", stat_fetch_abort, 32'(abort_exp));
`endif

        // Reset in the middle of a fetch must swallow it
        applyStimulus(1'b1, 32'h80, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_busy", 32'(bus.ifetch_busy), 32'd0);
        checkOutput("midrst_mem_a", bus.mem_a, 32'h0);
        checkOutput("midrst_inst", bus.IF_inst, 32'h0);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        checkOutput("midrst_idle", 32'(bus.ifetch_busy), 32'd0);

        checkOutput("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
